// File: rtl/axi_512_to_1024_pkg.sv
// Shared constants and types for the 512->1024 AXI4-Stream upsizer.
package axi_512_to_1024_pkg;
  localparam int IN_W_DFLT  = 512;
  localparam int KEEP_IN_W  = IN_W_DFLT / 8;
  localparam int KEEP_OUT_W = IN_W_DFLT / 4;

  // EMPTY: no half-beat held; HALF: lo_data/lo_keep hold beat 0 of a pair
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } pack_state_t;
endpackage

// File: rtl/axi_512_to_1024_if.sv
// Input (narrow) and output (wide) stream bundle of the upsizer; slave is the DUT side.
interface axi_512_to_1024_if #(
  parameter int IN_W = axi_512_to_1024_pkg::IN_W_DFLT
) ();
  logic [IN_W-1:0]     in_data;
  logic [IN_W/8-1:0]   in_keep;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;
  logic [2*IN_W-1:0]   out_data;
  logic [IN_W/4-1:0]   out_keep;
  logic                out_valid;
  logic                out_last;
  logic                out_ready;

  modport slave (
    input  in_data, in_keep, in_valid, in_last,
    output in_ready,
    output out_data, out_keep, out_valid, out_last,
    input  out_ready
  );

  modport master (
    output in_data, in_keep, in_valid, in_last,
    input  in_ready,
    input  out_data, out_keep, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/axi_512_to_1024.sv
// Packs pairs of IN_W beats into 2*IN_W beats (earlier beat low); out_valid one cycle after pair completes.
// in_ready follows the output slot only (free or popping this cycle); a stalled output holds lo and blocks input.
module axi_512_to_1024
  import axi_512_to_1024_pkg::*;
#(
  parameter int IN_W = IN_W_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  axi_512_to_1024_if.slave  bus
);
  localparam int OUT_W  = 2 * IN_W;
  localparam int KIN_W  = IN_W / 8;
  localparam int KOUT_W = IN_W / 4;

  pack_state_t        state, state_nxt;
  logic [IN_W-1:0]    lo_data;
  logic [KIN_W-1:0]   lo_keep;
  logic               lo_load;

  logic [OUT_W-1:0]   out_data_q, out_data_nxt;
  logic [KOUT_W-1:0]  out_keep_q, out_keep_nxt;
  logic               out_last_q, out_last_nxt;
  logic               out_valid_q, out_valid_nxt;
  logic               out_load;

  logic               out_free;
  logic               accept;

  assign out_free     = !out_valid_q || bus.out_ready;
  assign bus.in_ready = out_free && rst_n;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    lo_load      = 1'b0;
    out_load     = 1'b0;
    out_data_nxt = out_data_q;
    out_keep_nxt = out_keep_q;
    out_last_nxt = out_last_q;
    if (accept) begin
      unique case (state)
        ST_EMPTY: begin
          if (bus.in_last) begin
            // lone last beat: upper half is empty, pairing restarts next frame
            out_load     = 1'b1;
            out_data_nxt = {{IN_W{1'b0}}, bus.in_data};
            out_keep_nxt = {{KIN_W{1'b0}}, bus.in_keep};
            out_last_nxt = 1'b1;
          end else begin
            lo_load   = 1'b1;
            state_nxt = ST_HALF;
          end
        end
        ST_HALF: begin
          out_load     = 1'b1;
          out_data_nxt = {bus.in_data, lo_data};
          out_keep_nxt = {bus.in_keep, lo_keep};
          out_last_nxt = bus.in_last;
          state_nxt    = ST_EMPTY;
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
    out_valid_nxt = out_load || (out_valid_q && !bus.out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_data <= '0;
      lo_keep <= '0;
    end else if (lo_load) begin
      lo_data <= bus.in_data;
      lo_keep <= bus.in_keep;
    end
  end

  // loads only happen when the slot is free, so a stalled beat is never overwritten
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_nxt;
      out_data_q  <= out_data_nxt;
      out_keep_q  <= out_keep_nxt;
      out_last_q  <= out_last_nxt;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_keep  = out_keep_q;
  assign bus.out_last  = out_last_q;
endmodule
